// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer (master) and the RISCY datapath/memory (slave).
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instruction;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [3:0]       state;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instruction, mem_ready,
    output pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, state,
           illegal_op, mem_timeout, retired
  );

  modport slave (
    output instruction, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, state,
           illegal_op, mem_timeout, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer stepping RISCY instructions through fetch/decode/execute/memory/writeback,
// with a mem_ready watchdog, sticky trap flags and a retired-instruction counter.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_controller_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SLT   = 6'b010111;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_LW    = 6'b010101;
  localparam logic [5:0] OP_SW    = 6'b010110;
  localparam logic [5:0] OP_J     = 6'b011001;

  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  function automatic logic is_rfmt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SLT);
  endfunction

  function automatic logic is_ifmt(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_XORI) || (op == OP_SLTI);
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [5:0]       op_r;
  logic [5:0]       dec_op_s;
  logic [WD_W-1:0]  wd_cnt_r;
  logic             wd_expired_s;
  logic             timeout_hit_s;
  logic             is_wait_s;
  logic             retire_s;
  logic             illegal_r;
  logic             timeout_r;
  logic [CNT_W-1:0] retired_r;

  assign dec_op_s  = bus.instruction[31:26];
  assign is_wait_s = (state_r == S_FETCH) || (state_r == S_MEM_READ) || (state_r == S_MEM_WRITE);
  // A late mem_ready on the final watchdog cycle still wins over the trap.
  assign wd_expired_s = (TIMEOUT != 0) && is_wait_s && (wd_cnt_r == WD_LAST) && !bus.mem_ready;

  // Next-state selection.
  always_comb begin
    state_next_s  = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          if (state_r == S_FETCH) begin
            state_next_s = S_DECODE;
          end else if (state_r == S_MEM_READ) begin
            state_next_s = S_MEM_WB;
          end else begin
            state_next_s = S_FETCH;
          end
        end else if (wd_expired_s) begin
          state_next_s  = S_TRAP;
          timeout_hit_s = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      S_DECODE: begin
        if ((dec_op_s == OP_LW) || (dec_op_s == OP_SW)) begin
          state_next_s = S_MEM_ADDR;
        end else if (is_rfmt(dec_op_s) || is_ifmt(dec_op_s)) begin
          state_next_s = S_EXEC;
        end else if (dec_op_s == OP_BEQ) begin
          state_next_s = S_BRANCH;
        end else if (dec_op_s == OP_J) begin
          state_next_s = S_JUMP;
        end else begin
          state_next_s = S_TRAP;
        end
      end
      S_MEM_ADDR: state_next_s = (op_r == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_WB:   state_next_s = S_FETCH;
      S_EXEC:     state_next_s = S_ALU_WB;
      S_ALU_WB:   state_next_s = S_FETCH;
      S_BRANCH:   state_next_s = S_FETCH;
      S_JUMP:     state_next_s = S_FETCH;
      S_TRAP:     state_next_s = S_TRAP;
      default:    state_next_s = S_TRAP;
    endcase
  end

  // Every completing state exits to FETCH; TRAP and DECODE never do.
  assign retire_s = (state_next_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_DECODE)
                    && (state_r != S_TRAP);

  // State, latched opcode, watchdog, trap flags and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      op_r      <= 6'd0;
      wd_cnt_r  <= '0;
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == S_DECODE) begin
        op_r <= dec_op_s;
      end
      if ((state_r == S_DECODE) && (state_next_s == S_TRAP)) begin
        illegal_r <= 1'b1;
      end
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
      if (state_next_s != state_r) begin
        wd_cnt_r <= '0;
      end else if (is_wait_s && !bus.mem_ready) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  // Moore output decode; FETCH strobes also depend on mem_ready, everything is 0 in reset.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'b00;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 3'b000;
    if (reset) begin
      bus.mem_read = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE:   bus.alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = is_rfmt(op_r) ? 2'b00 : 2'b10;
          case (op_r)
            OP_RTYPE, OP_SLT: bus.alu_op = 3'b010;
            OP_ADDI:          bus.alu_op = 3'b011;
            OP_ANDI:          bus.alu_op = 3'b100;
            OP_XORI:          bus.alu_op = 3'b101;
            OP_SLTI:          bus.alu_op = 3'b110;
            default:          bus.alu_op = 3'b000;
          endcase
        end
        S_ALU_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = is_rfmt(op_r);
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 3'b001;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
        end
        default: bus.pc_write = 1'b0;
      endcase
    end
  end

  assign bus.state       = state_r;
  assign bus.illegal_op  = illegal_r;
  assign bus.mem_timeout = timeout_r;
  assign bus.retired     = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: expected state traces are built per instruction class from
// cycle-count rules and mem_ready wait counts, then compared cycle by cycle.
module tb_multicycle_controller;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SLT   = 6'b010111;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_LW    = 6'b010101;
  localparam logic [5:0] OP_SW    = 6'b010110;
  localparam logic [5:0] OP_J     = 6'b011001;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus_if ();

  multicycle_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int         pass_cnt    = 0;
  int         total_cnt   = 0;
  int         exp_retired = 0;
  logic [3:0] q_st[$];
  logic       q_rdy[$];
  logic [5:0] cur_op;
  logic [5:0] legal_ops [10] = '{OP_RTYPE, OP_SLT, OP_ADDI, OP_ANDI, OP_XORI,
                                 OP_SLTI, OP_BEQ, OP_LW, OP_SW, OP_J};

  function automatic logic is_r(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SLT);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    for (int i = 0; i < 10; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] exp_alu_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_SLT: return 3'b010;
      OP_ADDI:          return 3'b011;
      OP_ANDI:          return 3'b100;
      OP_XORI:          return 3'b101;
      OP_SLTI:          return 3'b110;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] ctrl_vec();
    return {bus_if.pc_write, bus_if.pc_write_cond, bus_if.pc_source, bus_if.ir_write,
            bus_if.i_or_d, bus_if.mem_read, bus_if.mem_write, bus_if.mem_to_reg,
            bus_if.reg_dst, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op};
  endfunction

  function void push_wait(input logic [3:0] st, input int waits);
    for (int i = 0; i < waits; i++) begin
      q_st.push_back(st);
      q_rdy.push_back(1'b0);
    end
    q_st.push_back(st);
    q_rdy.push_back(1'b1);
  endfunction

  function void push_any(input logic [3:0] st);
    q_st.push_back(st);
    q_rdy.push_back(1'($urandom_range(0, 1)));
  endfunction

  // Expected per-cycle state trace for one instruction (ready randomised where it is ignored).
  function void build_seq(input logic [5:0] op, input int wf, input int wm);
    q_st.delete();
    q_rdy.delete();
    push_wait(4'd0, wf);
    push_any(4'd1);
    if (op == OP_LW) begin
      push_any(4'd2);
      push_wait(4'd3, wm);
      push_any(4'd4);
    end else if (op == OP_SW) begin
      push_any(4'd2);
      push_wait(4'd5, wm);
    end else if (op == OP_BEQ) begin
      push_any(4'd8);
    end else if (op == OP_J) begin
      push_any(4'd9);
    end else begin
      push_any(4'd6);
      push_any(4'd7);
    end
  endfunction

  task automatic step(input logic [3:0] st, input logic rdy);
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    bus_if.mem_ready = rdy;
    @(negedge clk);
    total_cnt++;
    if (bus_if.state !== st) $display("FAIL state: got %0d expected %0d", bus_if.state, st);
    else pass_cnt++;
    exp_v = {(st == 4'd0) || (st == 4'd3), st == 4'd5, (st == 4'd4) || (st == 4'd7),
             (st == 4'd0) && rdy, ((st == 4'd0) && rdy) || (st == 4'd9), st == 4'd8,
             (st == 4'd3) || (st == 4'd5)};
    obs_v = {bus_if.mem_read, bus_if.mem_write, bus_if.reg_write, bus_if.ir_write,
             bus_if.pc_write, bus_if.pc_write_cond, bus_if.i_or_d};
    total_cnt++;
    if (obs_v !== exp_v) $display("FAIL strobes st%0d: got %b expected %b", st, obs_v, exp_v);
    else pass_cnt++;
    case (st)
      4'd0: begin
        total_cnt++;
        if ({bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.pc_source} !== 8'b0_01_000_00)
          $display("FAIL fetch_mux: got %b expected 00100000",
                   {bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.pc_source});
        else pass_cnt++;
      end
      4'd4: begin
        total_cnt++;
        if ({bus_if.mem_to_reg, bus_if.reg_dst} !== 2'b10)
          $display("FAIL mem_wb_mux: got %b expected 10", {bus_if.mem_to_reg, bus_if.reg_dst});
        else pass_cnt++;
      end
      4'd6: begin
        total_cnt++;
        if ({bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op} !==
            {1'b1, (is_r(cur_op) ? 2'b00 : 2'b10), exp_alu_op(cur_op)})
          $display("FAIL exec_mux op%b: got %b expected %b", cur_op,
                   {bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op},
                   {1'b1, (is_r(cur_op) ? 2'b00 : 2'b10), exp_alu_op(cur_op)});
        else pass_cnt++;
      end
      4'd7: begin
        total_cnt++;
        if ({bus_if.mem_to_reg, bus_if.reg_dst} !== {1'b0, is_r(cur_op)})
          $display("FAIL alu_wb_mux: got %b expected %b", {bus_if.mem_to_reg, bus_if.reg_dst},
                   {1'b0, is_r(cur_op)});
        else pass_cnt++;
      end
      4'd8: begin
        total_cnt++;
        if ({bus_if.pc_source, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op} !== 8'b01_1_00_001)
          $display("FAIL branch_mux: got %b expected 01100001",
                   {bus_if.pc_source, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op});
        else pass_cnt++;
      end
      4'd9: begin
        total_cnt++;
        if (bus_if.pc_source !== 2'b10) $display("FAIL jump_src: got %b expected 10", bus_if.pc_source);
        else pass_cnt++;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    logic [31:0]      r;
    logic [CNT_W-1:0] er;
    logic [3:0]       st;
    logic             rd;
    r = $urandom();
    cur_op = op;
    bus_if.instruction = {op, r[25:0]};
    build_seq(op, wf, wm);
    while (q_st.size() > 0) begin
      st = q_st.pop_front();
      rd = q_rdy.pop_front();
      step(st, rd);
    end
    exp_retired++;
    er = exp_retired[CNT_W-1:0];
    total_cnt++;
    if (bus_if.state !== 4'd0) $display("FAIL end_state op%b: got %0d expected 0", op, bus_if.state);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.retired !== er) $display("FAIL retired op%b: got %0d expected %0d", op, bus_if.retired, er);
    else pass_cnt++;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      bus_if.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      total_cnt++;
      if (ctrl_vec() !== 18'd0) $display("FAIL reset_strobes: got %h expected 0", ctrl_vec());
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_retired = 0;
    total_cnt++;
    if ({bus_if.state, bus_if.illegal_op, bus_if.mem_timeout} !== 6'b0000_0_0)
      $display("FAIL reset_state: got %b expected 000000",
               {bus_if.state, bus_if.illegal_op, bus_if.mem_timeout});
    else pass_cnt++;
    total_cnt++;
    if (bus_if.retired !== '0) $display("FAIL reset_retired: got %0d expected 0", bus_if.retired);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_addi();
    do_reset(1);
    run_instr(OP_ADDI, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LW, 0, 3);
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    logic [5:0]  op;
    do_reset(1);
    r = $urandom();
    cur_op = 6'b111111;
    bus_if.instruction = {6'b111111, r[25:0]};
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    repeat (20) begin
      bus_if.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      total_cnt++;
      if ({bus_if.state, bus_if.illegal_op, bus_if.mem_timeout} !== 6'b1010_1_0)
        $display("FAIL trap_hold: got %b expected 101010",
                 {bus_if.state, bus_if.illegal_op, bus_if.mem_timeout});
      else pass_cnt++;
      total_cnt++;
      if (ctrl_vec() !== 18'd0) $display("FAIL trap_strobes: got %h expected 0", ctrl_vec());
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      r = $urandom();
      cur_op = op;
      bus_if.instruction = {op, r[25:0]};
      step(4'd0, 1'b1);
      step(4'd1, 1'($urandom_range(0, 1)));
      total_cnt++;
      if ({bus_if.state, bus_if.illegal_op, bus_if.retired} !== {4'd10, 1'b1, 4'd0})
        $display("FAIL illegal_op%b: got %b expected 1010_1_0000", op,
                 {bus_if.state, bus_if.illegal_op, bus_if.retired});
      else pass_cnt++;
      do_reset(1);
    end
  endtask

  task automatic test_timeout();
    do_reset(1);
    cur_op = OP_ADDI;
    bus_if.instruction = {OP_ADDI, 26'd0};
    repeat (TIMEOUT) step(4'd0, 1'b0);
    total_cnt++;
    if ({bus_if.state, bus_if.mem_timeout, bus_if.illegal_op} !== 6'b1010_1_0)
      $display("FAIL fetch_timeout: got %b expected 101010",
               {bus_if.state, bus_if.mem_timeout, bus_if.illegal_op});
    else pass_cnt++;
    do_reset(1);
    run_instr(OP_ADDI, TIMEOUT - 1, 0);
    total_cnt++;
    if (bus_if.mem_timeout !== 1'b0) $display("FAIL ready_wins: got %b expected 0", bus_if.mem_timeout);
    else pass_cnt++;
    run_instr(OP_SW, 0, TIMEOUT - 1);
    do_reset(1);
    cur_op = OP_LW;
    bus_if.instruction = {OP_LW, 26'h155};
    step(4'd0, 1'b1);
    step(4'd1, 1'b0);
    step(4'd2, 1'b1);
    repeat (TIMEOUT) step(4'd3, 1'b0);
    total_cnt++;
    if ({bus_if.state, bus_if.mem_timeout, bus_if.retired} !== {4'd10, 1'b1, 4'd0})
      $display("FAIL read_timeout: got %b expected 1010_1_0000",
               {bus_if.state, bus_if.mem_timeout, bus_if.retired});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    cur_op = OP_SW;
    bus_if.instruction = {OP_SW, 26'h2a};
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    step(4'd2, 1'b0);
    step(4'd5, 1'b0);
    step(4'd5, 1'b0);
    reset = 1'b1;
    bus_if.mem_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus_if.state, ctrl_vec()} !== {4'd5, 18'd0})
      $display("FAIL reset_in_write: got %h expected %h", {bus_if.state, ctrl_vec()}, {4'd5, 18'd0});
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total_cnt++;
    if ({bus_if.state, bus_if.retired} !== 8'd0)
      $display("FAIL abort_write: got %h expected 0", {bus_if.state, bus_if.retired});
    else pass_cnt++;
    exp_retired = 0;
    run_instr(OP_ADDI, 0, 0);
  endtask

  task automatic test_random();
    do_reset(1);
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, TIMEOUT - 1),
                $urandom_range(0, TIMEOUT - 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.instruction = 32'd0;
    bus_if.mem_ready = 1'b0;
    cur_op = 6'd0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
